// File: rtl/sram_pkg.sv
// Shared types and constants for the 16-bit asynchronous SRAM data-memory controller.
package sram_pkg;
  typedef enum logic [1:0] {IDLE, LO, HI, DONE} sram_state_t;

  localparam int          SRAM_ADDR_W       = 18;
  localparam int          SRAM_DATA_W       = 16;
  localparam logic [31:0] DEF_BASE_ADDR     = 32'd1024;
  localparam int          DEF_ACCESS_CYCLES = 2;

  // Word index of a byte address relative to the SRAM base; the subtraction wraps modulo 2^32.
  function automatic logic [SRAM_ADDR_W-2:0] word_idx(input logic [31:0] addr,
                                                      input logic [31:0] base);
    logic [31:0] off;
    off = addr - base;
    return off[SRAM_ADDR_W:2];
  endfunction
endpackage

// File: rtl/sram_controller_if.sv
// Pipeline-side request bus between the EXE/MEM boundary and the SRAM controller.
interface sram_controller_if;
  logic        rd_en;
  logic        wr_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;

  modport master (output rd_en, wr_en, address, write_data, input read_data, ready);
  modport slave  (input rd_en, wr_en, address, write_data, output read_data, ready);
endinterface

// File: rtl/sram_controller.sv
// Moves one 32-bit word as two 16-bit halves over an async SRAM using fixed wait states;
// ready doubles as the pipeline's global freeze.
module sram_controller
  import sram_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR     = DEF_BASE_ADDR,
  parameter int          ACCESS_CYCLES = DEF_ACCESS_CYCLES
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  sram_controller_if.slave       bus,
  output logic [SRAM_ADDR_W-1:0] o_sram_addr,
  inout  wire  [SRAM_DATA_W-1:0] io_sram_dq,
  output logic                   o_sram_we_n
);
  localparam logic [3:0] LAST = 4'(ACCESS_CYCLES - 1);

  sram_state_t            r_state, w_next;
  logic [3:0]             r_cnt, w_cnt_nxt;
  logic                   r_wr;
  logic [SRAM_ADDR_W-2:0] r_widx;
  logic [31:0]            r_wdata;
  logic [31:0]            r_rdata;
  logic                   w_req, w_last, w_drive, w_start;
  logic [SRAM_DATA_W-1:0] w_dq_out;

  assign w_req   = bus.rd_en | bus.wr_en;
  assign w_last  = (r_cnt == LAST);
  assign w_start = (r_state == IDLE) && w_req;
  assign w_drive = r_wr && ((r_state == LO) || (r_state == HI));

  always_comb begin
    w_next    = r_state;
    w_cnt_nxt = r_cnt;
    case (r_state)
      IDLE: if (w_req) begin
        w_next    = LO;
        w_cnt_nxt = '0;
      end
      LO: if (w_last) begin
        w_next    = HI;
        w_cnt_nxt = '0;
      end else begin
        w_cnt_nxt = r_cnt + 4'd1;
      end
      HI: if (w_last) w_next = DONE;
          else        w_cnt_nxt = r_cnt + 4'd1;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Op, address and data are frozen at launch so mid-transaction input changes are ignored.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_wr    <= 1'b0;
      r_widx  <= '0;
      r_wdata <= '0;
    end else if (w_start) begin
      r_wr    <= bus.wr_en;
      r_widx  <= word_idx(bus.address, BASE_ADDR);
      r_wdata <= bus.write_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_rdata <= '0;
    end else if (!r_wr && w_last) begin
      if (r_state == LO) r_rdata[15:0]  <= io_sram_dq;
      if (r_state == HI) r_rdata[31:16] <= io_sram_dq;
    end
  end

  assign w_dq_out      = (r_state == HI) ? r_wdata[31:16] : r_wdata[15:0];
  assign io_sram_dq    = w_drive ? w_dq_out : {SRAM_DATA_W{1'bz}};
  assign o_sram_we_n   = ~w_drive;
  assign o_sram_addr   = {r_widx, (r_state == HI)};
  assign bus.ready     = ~w_req | (r_state == DONE);
  assign bus.read_data = r_rdata;
endmodule

// File: tb/tb_sram_controller.sv
// Self-checking bench: behavioural async SRAM plus a read-data scoreboard around sram_controller.
module tb_sram_controller;
  import sram_pkg::*;

  localparam int          N    = 2;
  localparam logic [31:0] BASE = 32'd1024;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sram_controller_if bus ();
  logic [SRAM_ADDR_W-1:0] sram_addr;
  wire  [SRAM_DATA_W-1:0] sram_dq;
  logic                   sram_we_n;

  // Behavioural SRAM: async read whenever not writing; probe mode drives zeros so a
  // stray controller drive on the bus becomes visible.
  logic [15:0] mem [0:(1<<18)-1];
  logic        probe = 1'b1;
  assign sram_dq = sram_we_n ? (probe ? 16'h0000 : mem[sram_addr]) : 16'hzzzz;

  int          n_chk  = 0;
  int          n_fail = 0;
  logic [31:0] exp_q[$];

  sram_controller #(.BASE_ADDR(BASE), .ACCESS_CYCLES(N)) dut (
    .i_clk       (clk),
    .i_rst       (rst_n),
    .bus         (bus),
    .o_sram_addr (sram_addr),
    .io_sram_dq  (sram_dq),
    .o_sram_we_n (sram_we_n)
  );

  initial begin
    for (int i = 0; i < (1 << 18); i++) mem[i] = 16'h0000;
    mem[4] = 16'h5678;
    mem[5] = 16'h1234;
    forever begin
      @(posedge clk);
      if (!sram_we_n) mem[sram_addr] = sram_dq;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Called at the start of an IDLE cycle (cycle 0); returns at the start of cycle 2N+2.
  task automatic do_req(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] rexp);
    logic [31:0] off;
    logic [17:0] w;
    off = a - BASE;
    w   = {off[18:2], 1'b0};
    bus.rd_en = rd; bus.wr_en = wr; bus.address = a; bus.write_data = d;
    probe = !(rd && !wr);
    if (rd && !wr) exp_q.push_back(rexp);
    for (int c = 0; c <= 2*N+1; c++) begin
      @(negedge clk);
      chk("ready", {31'd0, bus.ready}, {31'd0, (c == 2*N+1)});
      if (c >= 1 && c <= 2*N) begin
        chk("sram_addr", {14'd0, sram_addr}, {14'd0, w | {17'd0, (c > N)}});
        chk("we_n", {31'd0, sram_we_n}, {31'd0, !wr});
      end
      if (c == 2*N+1 && rd && !wr) begin
        if (exp_q.size() == 0) chk("sb_empty", 32'd1, 32'd0);
        else                   chk("read_data", bus.read_data, exp_q.pop_front());
      end
      @(posedge clk); #1;
    end
    bus.rd_en = 1'b0; bus.wr_en = 1'b0;
    probe = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout got=%0d exp=0", n_chk);
    $fatal(1, "timeout");
  end

  initial begin
    bus.rd_en = 1'b0; bus.wr_en = 1'b0; bus.address = '0; bus.write_data = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    @(negedge clk);
    chk("idle_ready", {31'd0, bus.ready}, 32'd1);
    chk("idle_we_n", {31'd0, sram_we_n}, 32'd1);
    chk("idle_dq_z", {16'd0, sram_dq}, 32'd0);
    chk("idle_rdata", bus.read_data, 32'd0);
    chk("idle_addr", {14'd0, sram_addr}, 32'd0);
    @(posedge clk); #1;

    do_req(1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, 32'd0);
    chk("wr_mem0", {16'd0, mem[0]}, 32'h0000BEEF);
    chk("wr_mem1", {16'd0, mem[1]}, 32'h0000DEAD);

    do_req(1'b1, 1'b0, 32'd1024, 32'd0, 32'hDEADBEEF);
    do_req(1'b1, 1'b0, 32'd1035, 32'd0, 32'h12345678);

    do_req(1'b1, 1'b1, 32'd1028, 32'hCAFEF00D, 32'd0);
    chk("both_mem2", {16'd0, mem[2]}, 32'h0000F00D);
    chk("both_mem3", {16'd0, mem[3]}, 32'h0000CAFE);
    chk("rdata_hold", bus.read_data, 32'h12345678);

    do_req(1'b0, 1'b1, 32'd0, 32'hA5A55A5A, 32'd0);
    chk("wrap_lo", {16'd0, mem[18'h3FE00]}, 32'h00005A5A);
    chk("wrap_hi", {16'd0, mem[18'h3FE01]}, 32'h0000A5A5);

    // Reset lands during the second LO cycle of a write.
    bus.wr_en = 1'b1; bus.address = 32'd1024; bus.write_data = 32'h55AA33CC;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    bus.wr_en = 1'b0;
    @(negedge clk);
    chk("rst_we_n", {31'd0, sram_we_n}, 32'd1);
    chk("rst_dq_z", {16'd0, sram_dq}, 32'd0);
    chk("rst_rdata", bus.read_data, 32'd0);
    chk("rst_ready", {31'd0, bus.ready}, 32'd1);
    chk("rst_addr", {14'd0, sram_addr}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("rst_mem0", {16'd0, mem[0]}, 32'h000033CC);
    chk("rst_mem1", {16'd0, mem[1]}, 32'h0000DEAD);

    // Flush: read dropped in cycle 1 still runs through DONE at cycle 5.
    probe = 1'b0;
    bus.rd_en = 1'b1; bus.address = 32'd1032;
    @(negedge clk);
    chk("flush_ready0", {31'd0, bus.ready}, 32'd0);
    @(posedge clk); #1;
    bus.rd_en = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      chk("flush_ready", {31'd0, bus.ready}, 32'd1);
      if (c <= 4) chk("flush_addr", {14'd0, sram_addr}, (c > 2) ? 32'd5 : 32'd4);
      if (c == 4) chk("flush_rd_lo", bus.read_data, 32'h00005678);
      if (c == 5) chk("flush_rd", bus.read_data, 32'h12345678);
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    probe = 1'b1;
    do_req(1'b0, 1'b1, 32'd1040, 32'h0BADF00D, 32'd0);
    chk("post_mem8", {16'd0, mem[8]}, 32'h0000F00D);
    chk("post_mem9", {16'd0, mem[9]}, 32'h00000BAD);
    chk("sb_drained", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/sram_controller.md
# sram_controller

Multi-cycle controller that sequences every data-memory access issued from the EXE/MEM boundary onto a 16-bit external asynchronous SRAM. It takes the byte address computed by the ALU plus the memory read/write enables, runs a fixed wait-state protocol to move one 32-bit word as two 16-bit halves, and drives `ready`, which the pipeline uses as its global freeze/stall signal.

## Interface
- `BASE_ADDR`, default 1024: byte address that maps to SRAM word 0.
- `ACCESS_CYCLES`, default 2 (legal 1–15): cycles each half-word access is held on the SRAM pins.
- `clk` input 1: single system clock; all state changes on the rising edge.
- `rst` input 1: reset, synchronous, active-low.
- `rd_en` input 1: load request; held high until `ready`.
- `wr_en` input 1: store request; held high until `ready`.
- `address` input 32: byte address from the ALU result.
- `write_data` input 32: store data.
- `read_data` output 32: load data; registered and stable from `ready` until the next load completes.
- `ready` output 1: high means no stall is needed.
- `sram_addr` output 18: SRAM half-word address.
- `sram_dq` inout 16: SRAM data bus.
- `sram_we_n` output 1: SRAM write strobe, active-low.

## Operation
- FSM states are `IDLE`, `LO`, `HI`, `DONE`. The wait counter `cnt` is 4 bits.
- **IDLE**
  - If `rd_en | wr_en` is high, latch the operation, go to `LO`, and set `cnt = 0`.
  - If both enables are high, the operation is a write.
- **LO**: drive the low half for `ACCESS_CYCLES` cycles, then go to `HI` and set `cnt = 0`.
- **HI**: drive the high half for `ACCESS_CYCLES` cycles, then go to `DONE`.
- **DONE**: stay one cycle, then return to `IDLE`.
- Address mapping:
  - Word index `w = (address - BASE_ADDR) >> 2`, computed with 32-bit modular subtraction.
  - `sram_addr = {w[16:0], half}`, where `half` is 0 in `LO` and 1 in `HI`.
  - `address[1:0]` is ignored.
  - Out-of-range addresses wrap modulo 2^18 half-words; there is no error signal.
- Writes:
  - `sram_we_n = 0` during all of `LO`/`HI`; otherwise 1.
  - `sram_dq` is driven with `write_data[15:0]` in `LO` and `write_data[31:16]` in `HI`.
  - In every other state, and for all reads, `sram_dq` is Z.
- Reads:
  - `sram_we_n = 1`.
  - `read_data[15:0]` is captured from `sram_dq` on the last `LO` cycle.
  - `read_data[31:16]` is captured on the last `HI` cycle.
- `ready = ~(rd_en | wr_en) | (state == DONE)`. This is combinational, so the pipeline freezes in the same cycle the request appears.
- `address`, `write_data` and the op are latched when leaving `IDLE`; input changes mid-transaction have no effect.
- A request dropped mid-transaction (for example by a pipeline flush) does not abort it. The FSM finishes through `DONE`, and `ready` is 1 as soon as both enables are low.
- A request still high in `DONE` is not re-issued; the next transaction starts only from `IDLE`.

## Timing
- Reset (`rst = 0` at a clock edge):
  - `state = IDLE`, `cnt = 0`, `read_data = 0`, `sram_we_n = 1`, `sram_dq` = Z, `sram_addr = 0`.
  - `ready` then follows its combinational equation.
- Reset mid-transaction takes effect at the next edge: the access is abandoned, `sram_we_n` rises, and a partial write of the low half may remain in SRAM.
- Request first high in cycle 0 (`state = IDLE`):
  - `LO` occupies cycles 1..N.
  - `HI` occupies cycles N+1..2N.
  - `DONE` is cycle 2N+1, with `ready = 1`.
  - `IDLE` is cycle 2N+2.
  - With N = 2: `ready` is low in cycles 0–4 and high in cycle 5; total stall is 2N+1 cycles.
- The address and write data are stable on the pins for the whole N-cycle window of each half.
- `sram_we_n` deasserts in the same cycle the state leaves `HI`.
- Back-to-back requests: the minimum spacing between the starts of two transactions is 2N+2 cycles.

## Structure
- Shared package `sram_pkg`:
  - enum `sram_state_t {IDLE, LO, HI, DONE}`;
  - constants `SRAM_ADDR_W = 18` and `SRAM_DATA_W = 16`;
  - default `BASE_ADDR` and `ACCESS_CYCLES` values.
- No sub-module: the FSM, wait counter, latches and tri-state driver are a single module.
- Read timing is checked in the bench with a behavioural SRAM model (`sram_model`). It has 2^18 × 16 storage, writes on `sram_we_n` low, and asynchronous read.

## Test plan
- **Idle**: no request, after reset → `ready = 1`, `sram_we_n = 1`, `sram_dq` = Z, `read_data = 0`.
- **Write**: N = 2, `wr_en`, `address = 1024`, `write_data = 0xDEADBEEF` at cycle 0 → SRAM[0] = 0xBEEF and SRAM[1] = 0xDEAD; `ready` low in cycles 0–4, high in cycle 5.
- **Read back**: `rd_en`, `address = 1024` → `read_data = 0xDEADBEEF` in cycle 5. A second read at `address = 1032` (preloaded SRAM[4] = 0x5678, SRAM[5] = 0x1234) → `read_data = 0x12345678`, `sram_addr` sequence 4 then 5.
- **Both enables**: `rd_en = wr_en = 1`, `address = 1028`, data 0xCAFEF00D → treated as a write; SRAM[2] = 0xF00D, SRAM[3] = 0xCAFE.
- **Reset mid-write**: `rst` low in cycle 2 of a write → next cycle `IDLE`, `sram_we_n = 1`, `sram_dq` = Z; SRAM[1] is unchanged.
- **Flush**: request dropped in cycle 1 → `ready = 1` from cycle 1, the FSM still reaches `DONE` at cycle 5, and the next request in cycle 7 is serviced normally.
